ram_cmd_driver: RTL and testbench
=================================

# ram_cmd_driver

Stimulus-side counterpart of the RAM output monitor interface. Accepts write/read commands over a valid/ready handshake, queues them, and drives the 16x4 RAM's input pins (address, data, write/read strobes) with exact cycle timing. For reads, it samples the RAM's `q` bus after a fixed latency and returns the value as a one-cycle response. Sits between the testbench generator/sequencer and the RAM DUT input pins.

## Interface
- `ADDR_W`, default 4: RAM address width.
- `DATA_W`, default 4: RAM data width, equal to `q` width.
- `DEPTH`, default 4: command FIFO entries; power of 2, ≥2.
- `RD_LAT`, default 1: rising edges from the edge that asserts `ram_re` to the edge that samples `ram_q`; range 1..15.

Ports:
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  FIFO can accept; equals !full.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  ADDR_W  target address.
- `cmd_data`  in  DATA_W  write data; ignored for reads.
- `ram_addr`  out  ADDR_W  to RAM address pins.
- `ram_data`  out  DATA_W  to RAM data-in pins.
- `ram_we`  out  1  write strobe.
- `ram_re`  out  1  read strobe.
- `ram_q`  in  DATA_W  RAM read data (the monitored `q`).
- `rsp_valid`  out  1  one-cycle pulse: `rsp_data` valid.
- `rsp_data`  out  DATA_W  captured read data.
- `busy`  out  1  state != IDLE or FIFO non-empty.

## Operation
- Accept a command on a rising edge with `cmd_valid && cmd_ready`. Push {write, addr, data} into the FIFO.
- When full, `cmd_ready` = 0; there is no same-cycle pass-through. A push and a pop in the same edge are both legal when not full.
- FSM states: IDLE, WR, RD, WAIT. All pin outputs are registered.
  - IDLE or WR, FIFO non-empty: pop the head.
    - Write: next state WR, `ram_we`=1, `ram_addr`/`ram_data` from the entry.
    - Read: next state RD, `ram_re`=1, `ram_addr` from the entry.
  - IDLE or WR, FIFO empty: next state IDLE, `ram_we`=0. `ram_addr`/`ram_data` hold their last values.
  - RD (one cycle): `ram_re`=1.
    - RD_LAT=1: sample `ram_q` at the edge leaving RD, go to IDLE.
    - Otherwise: go to WAIT with counter = RD_LAT−1, `ram_re`=0.
  - WAIT: decrement the counter each edge. At the edge where the counter reaches 0, sample `ram_q` and go to IDLE. `ram_addr` holds.
- On a sample edge, load `rsp_data` <= `ram_q` and set `rsp_valid`=1 for exactly the following cycle. `rsp_data` holds until the next sample.
- Ordering: strictly FIFO order. A write queued behind a read is not issued until the read's sample edge has passed.
- `ram_we` and `ram_re` are never both 1.

## Timing
- Reset (asynchronous, `rst_n`=0): state IDLE, FIFO empty.
  - `cmd_ready`=1, `ram_we`=0, `ram_re`=0, `ram_addr`=0, `ram_data`=0, `rsp_valid`=0, `rsp_data`=0, `busy`=0.
- Reset mid-operation: queued commands are discarded, and an in-flight read produces no `rsp_valid`. Outputs take reset values immediately, not at the next edge.
- Command accepted at edge E into an empty, idle block: pins are driven after edge E+1.
- Write throughput: back-to-back writes give `ram_we` high continuously, one write per cycle, with address/data changing each cycle.
- Read occupancy: a read occupies 1+ (RD_LAT−1) cycles. With `ram_re` asserted after edge S, `ram_q` is sampled at edge S+RD_LAT, and `rsp_valid` is high in the cycle after S+RD_LAT.
- Next command after a read is issued at the sample edge at the earliest, so pins change after S+RD_LAT.
- `busy` is registered consistently with the state and FIFO count; it falls the cycle after the last `ram_we` or the final sample edge.
- FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH. The count is log2(DEPTH)+1 bits; full = count==DEPTH.

## Test plan
- Reset then idle: hold `rst_n`=0 for 3 cycles, then release. Required: all outputs 0, `cmd_ready`=1, `busy`=0; no strobes for 10 cycles.
- Single write then read (RD_LAT=1): write addr 4'h3 data 4'hA, then read addr 4'h3, with a RAM model returning 4'hA.
  - Required: `ram_we` high for exactly 1 cycle with addr 3/data A.
  - Then `ram_re` high for 1 cycle with addr 3, followed by `rsp_valid` pulse with `rsp_data`=4'hA.
- Back-to-back writes: 4 writes to addrs 0..3 with data 5,6,7,8, `cmd_valid` held high.
  - Required: `ram_we` high for 4 consecutive cycles with matching addr/data in order.
  - `cmd_ready` never drops while DEPTH=4 drains concurrently.
- FIFO full: stall issue with a read at RD_LAT=4, then offer 6 commands.
  - Required: `cmd_ready`=0 after 4 are queued; no command lost or duplicated; issue order preserved.
- Read latency (RD_LAT=3): drive `ram_q`=4'h5 only at the 3rd edge after `ram_re` rises, with other values elsewhere.
  - Required: `rsp_data`=4'h5; `ram_we` stays 0 until the sample edge.
- Reset mid-read: assert `rst_n`=0 during WAIT. Required: no `rsp_valid`, FIFO empty, outputs at reset values immediately.

Source files
------------

// File: rtl/ram_cmd_driver.sv
// Purpose : queues write/read commands and drives RAM input pins with exact cycle timing; returns read data.
// Latency : pins change one edge after the command is queued (idle); read data sampled RD_LAT edges after ram_re.
// Backpres: cmd_ready = !full (registered count); no same-cycle pass-through; one pop per edge while issuing.
//
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   cmd_valid/cmd_ready                command handshake
//   cmd_write, cmd_addr, cmd_data      command payload (1 = write, 0 = read)
//   ram_addr, ram_data, ram_we, ram_re registered RAM input pins
//   ram_q                              RAM read data
//   rsp_valid, rsp_data                one-cycle read response, data held until next sample
//   busy                               FSM not idle or commands queued
module ram_cmd_driver #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 4,
   parameter int DEPTH  = 4,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_data,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_data,
   output logic              ram_we,
   output logic              ram_re,
   input  logic [DATA_W-1:0] ram_q,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic              busy
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int LAT_W = 4;

   typedef struct packed {
      logic              write;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } cmd_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WR   = 2'd1,
      RD   = 2'd2,
      WAIT = 2'd3
   } state_t;

   // ------------------------------------------------------------------
   // Command FIFO: power-of-two depth, pointers wrap naturally,
   // count is one bit wider so full and empty are unambiguous.
   // ------------------------------------------------------------------
   cmd_t             fifo_mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_nxt;
   logic             fifo_full;
   logic             fifo_empty;
   logic             push;
   logic             pop;
   cmd_t             cmd_in;
   cmd_t             head;

   assign fifo_full  = (count == CNT_W'(DEPTH));
   assign fifo_empty = (count == '0);
   assign cmd_ready  = !fifo_full;
   assign push       = cmd_valid && !fifo_full;

   assign cmd_in.write = cmd_write;
   assign cmd_in.addr  = cmd_addr;
   assign cmd_in.data  = cmd_data;
   assign head         = fifo_mem[rd_ptr];

   // pop is only raised by the FSM when the FIFO is non-empty
   always_comb begin
      count_nxt = count;
      case ({push, pop})
         2'b10:   count_nxt = count + 1'b1;
         2'b01:   count_nxt = count - 1'b1;
         default: count_nxt = count;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count_nxt;
      end
   end

   // storage needs no reset: an entry is only read after it was written
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= cmd_in;
   end

   // ------------------------------------------------------------------
   // Issue FSM
   // ------------------------------------------------------------------
   state_t           state;
   state_t           state_nxt;
   logic [LAT_W-1:0] lat_cnt;
   logic [LAT_W-1:0] lat_cnt_nxt;
   logic             sample;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         lat_cnt <= '0;
      end else begin
         state   <= state_nxt;
         lat_cnt <= lat_cnt_nxt;
      end
   end

   // Reads block further issue until their sample edge, which keeps the
   // pins in strict FIFO order and never overlaps ram_we with ram_re.
   always_comb begin
      state_nxt   = state;
      lat_cnt_nxt = lat_cnt;
      pop         = 1'b0;
      sample      = 1'b0;
      case (state)
         IDLE, WR: begin
            if (!fifo_empty) begin
               pop       = 1'b1;
               state_nxt = head.write ? WR : RD;
            end else begin
               state_nxt = IDLE;
            end
         end
         RD: begin
            if (RD_LAT == 1) begin
               sample    = 1'b1;
               state_nxt = IDLE;
            end else begin
               lat_cnt_nxt = LAT_W'(RD_LAT - 1);
               state_nxt   = WAIT;
            end
         end
         WAIT: begin
            lat_cnt_nxt = lat_cnt - 1'b1;
            if (lat_cnt == LAT_W'(1)) begin
               sample    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Registered pin / response outputs
   // ------------------------------------------------------------------
   logic [ADDR_W-1:0] ram_addr_nxt;
   logic [DATA_W-1:0] ram_data_nxt;
   logic              ram_we_nxt;
   logic              ram_re_nxt;
   logic              rsp_valid_nxt;
   logic [DATA_W-1:0] rsp_data_nxt;
   logic              busy_nxt;

   // ram_re is only set on the edge entering RD, so it lasts exactly the
   // RD cycle; address/data hold whenever nothing is issued.
   always_comb begin
      ram_addr_nxt  = ram_addr;
      ram_data_nxt  = ram_data;
      ram_we_nxt    = 1'b0;
      ram_re_nxt    = 1'b0;
      rsp_valid_nxt = sample;
      rsp_data_nxt  = sample ? ram_q : rsp_data;
      if (pop) begin
         ram_addr_nxt = head.addr;
         if (head.write) begin
            ram_we_nxt   = 1'b1;
            ram_data_nxt = head.data;
         end else begin
            ram_re_nxt = 1'b1;
         end
      end
      busy_nxt = (state_nxt != IDLE) || (count_nxt != '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ram_addr  <= '0;
         ram_data  <= '0;
         ram_we    <= 1'b0;
         ram_re    <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         busy      <= 1'b0;
      end else begin
         ram_addr  <= ram_addr_nxt;
         ram_data  <= ram_data_nxt;
         ram_we    <= ram_we_nxt;
         ram_re    <= ram_re_nxt;
         rsp_valid <= rsp_valid_nxt;
         rsp_data  <= rsp_data_nxt;
         busy      <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_ram_cmd_driver.sv
// Purpose : exercises three ram_cmd_driver instances (RD_LAT 1/3/4) through one shared stimulus port.
// Latency : expectations queued at command acceptance, compared when the pins / response appear.
// Backpres: stimulus holds cmd_valid until cmd_ready is seen; every wait is bounded.
module tb_ram_cmd_driver;

   localparam int LAT_TAB [3] = '{1, 3, 4};

   typedef struct packed {
      logic       write;
      logic [3:0] addr;
      logic [3:0] data;
   } pin_t;

   logic       clk;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_write;
   logic [3:0] cmd_addr;
   logic [3:0] cmd_data;
   logic [3:0] ram_q;
   logic [1:0] sel;

   logic       cmd_ready_v [3];
   logic [3:0] ram_addr_v  [3];
   logic [3:0] ram_data_v  [3];
   logic       ram_we_v    [3];
   logic       ram_re_v    [3];
   logic       rsp_valid_v [3];
   logic [3:0] rsp_data_v  [3];
   logic       busy_v      [3];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      ram_cmd_driver #(
         .ADDR_W(4), .DATA_W(4), .DEPTH(4), .RD_LAT(LAT_TAB[g])
      ) u_dut (
         .clk      (clk),
         .rst_n    (rst_n),
         .cmd_valid(cmd_valid && (sel == 2'(g))),
         .cmd_ready(cmd_ready_v[g]),
         .cmd_write(cmd_write),
         .cmd_addr (cmd_addr),
         .cmd_data (cmd_data),
         .ram_addr (ram_addr_v[g]),
         .ram_data (ram_data_v[g]),
         .ram_we   (ram_we_v[g]),
         .ram_re   (ram_re_v[g]),
         .ram_q    (ram_q),
         .rsp_valid(rsp_valid_v[g]),
         .rsp_data (rsp_data_v[g]),
         .busy     (busy_v[g])
      );
   end

   // observed outputs of the selected instance
   logic       cmd_ready_o, ram_we_o, ram_re_o, rsp_valid_o, busy_o;
   logic [3:0] ram_addr_o, ram_data_o, rsp_data_o;
   assign cmd_ready_o = cmd_ready_v[sel];
   assign ram_we_o    = ram_we_v[sel];
   assign ram_re_o    = ram_re_v[sel];
   assign rsp_valid_o = rsp_valid_v[sel];
   assign busy_o      = busy_v[sel];
   assign ram_addr_o  = ram_addr_v[sel];
   assign ram_data_o  = ram_data_v[sel];
   assign rsp_data_o  = rsp_data_v[sel];

   // behavioural RAM plus an override used to pin down the sample edge
   logic [3:0] mem [16] = '{default: 4'h0};
   logic       q_force;
   logic [3:0] q_force_val;
   assign ram_q = q_force ? q_force_val : mem[ram_addr_o];
   always @(posedge clk) if (ram_we_o) mem[ram_addr_o] <= ram_data_o;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int         n_checks = 0;
   int         n_fail   = 0;
   pin_t       exp_pin [$];
   logic [3:0] exp_rsp [$];
   logic [3:0] refmem [16] = '{default: 4'h0};
   logic       rsp_force_en;
   logic [3:0] rsp_force_val;
   int         cyc = 0, last_re_cyc = 0;
   int         we_run = 0, max_we_run = 0, strobe_cnt = 0, rsp_cnt = 0, pin_cnt = 0;

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // pin / response monitor, sampled on the falling edge
   always @(negedge clk) begin
      pin_t e;
      cyc++;
      if (ram_we_o) begin
         we_run++;
         if (we_run > max_we_run) max_we_run = we_run;
      end else begin
         we_run = 0;
      end
      if (ram_we_o || ram_re_o) begin
         strobe_cnt++;
         check_eq("we_re_excl", int'(ram_we_o && ram_re_o), 0);
         if (exp_pin.size() == 0) begin
            check_eq("unexp_strobe", 1, 0);
         end else begin
            e = exp_pin.pop_front();
            pin_cnt++;
            check_eq("pin_op", int'(ram_we_o), int'(e.write));
            check_eq("pin_addr", int'(ram_addr_o), int'(e.addr));
            if (e.write) check_eq("pin_data", int'(ram_data_o), int'(e.data));
         end
      end
      if (ram_re_o) last_re_cyc = cyc;
      if (rsp_valid_o) begin
         rsp_cnt++;
         check_eq("rsp_lat", cyc - last_re_cyc, LAT_TAB[sel]);
         if (exp_rsp.size() == 0) check_eq("unexp_rsp", 1, 0);
         else check_eq("rsp_data", int'(rsp_data_o), int'(exp_rsp.pop_front()));
      end
   end

   // offer one command; on acceptance queue its expected pin event / response
   task automatic send(input logic w, input logic [3:0] a, input logic [3:0] d, output int waited);
      pin_t e;
      waited    = 0;
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_addr  = a;
      cmd_data  = d;
      @(negedge clk);
      while (!cmd_ready_o && waited < 100) begin
         waited++;
         @(negedge clk);
      end
      if (!cmd_ready_o) begin
         check_eq("send_timeout", 1, 0);
      end else begin
         e.write = w;
         e.addr  = a;
         e.data  = d;
         exp_pin.push_back(e);
         if (w) refmem[a] = d;
         else exp_rsp.push_back(rsp_force_en ? rsp_force_val : refmem[a]);
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((busy_o || exp_pin.size() != 0 || exp_rsp.size() != 0) && n < 200);
      if (n >= 200) check_eq("idle_timeout", 1, 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish, required finish before 100000");
      $fatal(1);
   end

   initial begin
      int w, wsum, r0;
      pin_t ops [6];
      rst_n = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_data = '0;
      sel = 2'd0; q_force = 1'b0; q_force_val = '0; rsp_force_en = 1'b0; rsp_force_val = '0;
      #1 rst_n = 1'b0;

      // ---- reset then idle ----
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_eq("rst_ready", int'(cmd_ready_o), 1);
      check_eq("rst_busy", int'(busy_o), 0);
      check_eq("rst_we_re", int'(ram_we_o | ram_re_o), 0);
      check_eq("rst_addr_data", int'({ram_addr_o, ram_data_o}), 0);
      check_eq("rst_rsp", int'({rsp_valid_o, rsp_data_o}), 0);
      strobe_cnt = 0;
      repeat (10) @(negedge clk);
      check_eq("idle_strobes", strobe_cnt, 0);
      check_eq("idle_busy", int'(busy_o), 0);
      @(posedge clk);
      #1;

      // ---- single write then read, RD_LAT=1 ----
      sel = 2'd0; max_we_run = 0; r0 = rsp_cnt;
      send(1'b1, 4'h3, 4'hA, w);
      check_eq("wr_busy_after_accept", int'(busy_o), 1);
      @(negedge clk);
      check_eq("issue_lat_e", int'(ram_we_o), 0);
      @(negedge clk);
      check_eq("issue_lat_e1", int'(ram_we_o), 1);
      @(posedge clk);
      #1;
      send(1'b0, 4'h3, 4'h0, w);
      wait_idle();
      check_eq("wr_pulse_len", max_we_run, 1);
      check_eq("rd_rsp_count", rsp_cnt - r0, 1);
      check_eq("rd_rsp_hold", int'(rsp_data_o), 4'hA);

      // ---- back-to-back writes ----
      max_we_run = 0; wsum = 0;
      for (int i = 0; i < 4; i++) begin
         send(1'b1, 4'(i), 4'(i + 5), w);
         wsum += w;
      end
      wait_idle();
      check_eq("b2b_ready_drop", wsum, 0);
      check_eq("b2b_we_run", max_we_run, 4);

      // ---- FIFO full behind a stalled read, RD_LAT=4 ----
      sel = 2'd2; r0 = pin_cnt; wsum = 0;
      ops[0] = '{1'b1, 4'h8, 4'h1};
      ops[1] = '{1'b1, 4'h9, 4'h2};
      ops[2] = '{1'b0, 4'h8, 4'h0};
      ops[3] = '{1'b1, 4'hA, 4'h3};
      ops[4] = '{1'b1, 4'hB, 4'h4};
      ops[5] = '{1'b1, 4'hC, 4'h5};
      send(1'b0, 4'h1, 4'h0, w);
      for (int i = 0; i < 6; i++) begin
         send(ops[i].write, ops[i].addr, ops[i].data, w);
         if (i < 4) wsum += w;
         if (i == 3) check_eq("full_ready_low", int'(cmd_ready_o), 0);
         if (i == 4) check_eq("full_stalled", int'(w > 0), 1);
      end
      check_eq("full_prefill_nowait", wsum, 0);
      wait_idle();
      check_eq("full_issue_cnt", pin_cnt - r0, 7);

      // ---- read latency, RD_LAT=3: 5 only valid across the sample edge ----
      sel = 2'd1; q_force = 1'b1; q_force_val = 4'h9;
      rsp_force_en = 1'b1; rsp_force_val = 4'h5;
      fork
         begin : watch
            int n;
            n = 0;
            do begin
               @(negedge clk);
               n++;
            end while (!ram_re_o && n < 50);
            check_eq("lat_re_seen", int'(ram_re_o), 1);
            check_eq("lat_we_s0", int'(ram_we_o), 0);
            @(negedge clk);
            check_eq("lat_we_s1", int'(ram_we_o), 0);
            @(negedge clk);
            check_eq("lat_we_s2", int'(ram_we_o), 0);
            q_force_val = 4'h5;
            @(negedge clk);
            q_force_val = 4'hC;
         end
         begin
            send(1'b0, 4'h5, 4'h0, w);
            rsp_force_en = 1'b0;
            send(1'b1, 4'h6, 4'h1, w);
         end
      join
      wait_idle();
      q_force = 1'b0;
      check_eq("lat_rsp_hold", int'(rsp_data_o), 4'h5);

      // ---- reset during WAIT ----
      sel = 2'd1;
      send(1'b0, 4'h2, 4'h0, w);
      send(1'b0, 4'h4, 4'h0, w);
      @(posedge clk);
      #1;
      check_eq("pre_rst_busy", int'(busy_o), 1);
      check_eq("pre_rst_addr", int'(ram_addr_o), 4'h2);
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_re", int'(ram_re_o), 0);
      check_eq("mid_rst_addr", int'(ram_addr_o), 0);
      check_eq("mid_rst_rsp_data", int'(rsp_data_o), 0);
      check_eq("mid_rst_busy", int'(busy_o), 0);
      check_eq("mid_rst_ready", int'(cmd_ready_o), 1);
      exp_pin.delete();
      exp_rsp.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      strobe_cnt = 0; r0 = rsp_cnt;
      repeat (10) @(negedge clk);
      check_eq("post_rst_strobes", strobe_cnt, 0);
      check_eq("post_rst_rsp", rsp_cnt - r0, 0);
      check_eq("post_rst_busy", int'(busy_o), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
